// File: rtl/alu16_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial 16-bit ALU.
// Holds the operation codes, the controller state enum, the datapath
// geometry (16-bit word processed as 4 nibbles) and a small op helper.
package alu16_nibble_seq_pkg;

  localparam int DATA_W    = 16;
  localparam int NIB_W     = 4;
  localparam int NIBBLES   = 4;
  localparam int NIB_IDX_W = 2;

  localparam logic [NIB_IDX_W-1:0] LAST_NIB = NIB_IDX_W'(NIBBLES - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Only ADD and SUB report carry and signed overflow.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu16_nibble_seq_if.sv
// Request/result bus of the nibble-serial ALU.
// Request side : in_valid, in_ready, a, b, op
// Result side  : out_valid, out_ready, result, cout, overflow, zero
// master = requester/consumer (drives operands and out_ready),
// slave  = the ALU (drives in_ready and the result fields).
interface alu16_nibble_seq_if;
  import alu16_nibble_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [2:0]        op;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              cout;
  logic              overflow;
  logic              zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero
  );

endinterface

// File: rtl/alu16_nibble_seq_alu4bit.sv
// ALU4Bit: combinational 4-bit ALU slice.
// Ports: a, b (4-bit operands), cin, less (value driven on bit 0 for SLT),
// op (bit 2 inverts b, bits 1:0 select AND/OR/ADD/LESS),
// result (4-bit), cout, overflow (carry into bit 3 xor carry out),
// set (sum bit 3, used by the caller for SLT).
module ALU4Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       less,
  input  logic [2:0] op,
  output logic [3:0] result,
  output logic       cout,
  output logic       overflow,
  output logic       set
);

  logic [3:0] b_sel;
  logic [4:0] sum;
  logic [3:0] low_sum;

  always_comb begin
    b_sel    = op[2] ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_sel} + {4'b0000, cin};
    // Carry into bit 3 is needed separately for the overflow flag.
    low_sum  = {1'b0, a[2:0]} + {1'b0, b_sel[2:0]} + {3'b000, cin};
    cout     = sum[4];
    overflow = low_sum[3] ^ sum[4];
    set      = sum[3];
    case (op[1:0])
      2'b00:   result = a & b_sel;
      2'b01:   result = a | b_sel;
      2'b10:   result = sum[3:0];
      default: result = {3'b000, less};
    endcase
  end

endmodule

// File: rtl/alu16_nibble_seq.sv
// alu16_nibble_seq: 16-bit ALU that reuses one 4-bit slice over four cycles.
// Ports: clk, rst_n (async active-low), bus (slave side of
// alu16_nibble_seq_if: valid/ready request with a/b/op, valid/ready result
// with result/cout/overflow/zero).
// Flow: IDLE accepts a request, RUN processes nibble 0..3 LSB first with the
// carry chained through a register, DONE presents the result until taken.
module alu16_nibble_seq
  import alu16_nibble_seq_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  alu16_nibble_seq_if.slave bus
);

  state_t                   state;
  state_t                   state_nxt;
  logic                     in_ready_c;
  logic                     out_valid_c;

  logic [DATA_W-1:0]        a_q;
  logic [DATA_W-1:0]        b_q;
  logic [2:0]               op_q;
  // Lower three result nibbles; the top nibble comes straight from the slice.
  logic [DATA_W-NIB_W-1:0]  acc;
  logic [NIB_IDX_W-1:0]     k;
  logic                     carry;

  logic [DATA_W-1:0]        result_q;
  logic                     cout_q;
  logic                     ovf_q;
  logic                     zero_q;

  logic [NIB_W-1:0]         s_a;
  logic [NIB_W-1:0]         s_b;
  logic [NIB_W-1:0]         s_res;
  logic                     s_cout;
  logic                     s_ovf;
  logic                     s_set;

  logic                     accept;
  logic                     running;
  logic                     last_nib;
  logic [DATA_W-1:0]        final_res;

  // SLT collapses to the sign of a-b; unsupported codes return zero.
  function automatic logic [DATA_W-1:0] fixup(input logic [2:0]        op,
                                              input logic [DATA_W-1:0] raw,
                                              input logic              set);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: fixup = raw;
      OP_SLT:                        fixup = {{(DATA_W-1){1'b0}}, set};
      default:                       fixup = '0;
    endcase
  endfunction

  assign accept    = bus.in_valid && (state == ST_IDLE);
  assign running   = (state == ST_RUN);
  assign last_nib  = running && (k == LAST_NIB);
  assign s_a       = a_q[{k, 2'b00} +: NIB_W];
  assign s_b       = b_q[{k, 2'b00} +: NIB_W];
  assign final_res = fixup(op_q, {s_res, acc}, s_set);

  ALU4Bit u_slice (
    .a        (s_a),
    .b        (s_b),
    .cin      (carry),
    .less     (1'b0),
    .op       (op_q),
    .result   (s_res),
    .cout     (s_cout),
    .overflow (s_ovf),
    .set      (s_set)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.in_valid)  state_nxt = ST_RUN;
      ST_RUN:  if (k == LAST_NIB) state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready_c  = (state == ST_IDLE);
    out_valid_c = (state == ST_DONE);
  end

  // Control and visible results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= '0;
      carry    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else if (accept) begin
      k        <= '0;
      // SUB/SLT need the +1 of two's complement on the first nibble.
      carry    <= bus.op[2];
    end else if (running) begin
      k        <= k + 1'b1;
      carry    <= s_cout;
      // Outputs change only on completion so they hold across idle periods.
      if (last_nib) begin
        result_q <= final_res;
        cout_q   <= is_arith(op_q) ? s_cout : 1'b0;
        ovf_q    <= is_arith(op_q) ? s_ovf  : 1'b0;
        zero_q   <= (final_res == '0);
      end
    end
  end

  // Operand capture and partial result nibbles
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      op_q <= bus.op;
    end
    if (running) begin
      case (k)
        2'd0:    acc[3:0]  <= s_res;
        2'd1:    acc[7:4]  <= s_res;
        2'd2:    acc[11:8] <= s_res;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: doc/alu16_nibble_seq.md
ALU16_NIBBLE_SEQ -- requirements
Module: alu16_nibble_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, the single rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 in_valid  input  1  operation request valid.
REQ-003 in_ready  output 1  block can accept a request.
REQ-004 a  input  16  operand A.
REQ-005 b  input  16  operand B.
REQ-006 op  input  3  operation code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others unsupported.
REQ-007 out_valid  output 1  result available.
REQ-008 out_ready  input  1  consumer accepts result.
REQ-009 result  output 16  operation result.
REQ-010 cout  output 1  carry out of bit 15.
REQ-011 overflow  output 1  signed overflow.
REQ-012 zero  output 1  result == 0.

Function
REQ-013 States SHALL be IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 On in_valid & in_ready, a/b/op SHALL be captured, nibble index cleared to 0, carry register loaded with op[2], and state SHALL go to RUN.
REQ-015 In RUN, each cycle SHALL apply nibble k (bits 4k+3..4k) of captured a/b, the carry register as cin and less=0 to the 4-bit slice, store the slice result into result bits 4k+3..4k, load the carry register with the slice cout, and increment k.
REQ-016 After nibble 3 (4 RUN cycles), state SHALL go to DONE and out_valid SHALL assert on the next cycle; accept-to-out_valid latency is exactly 5 cycles.
REQ-017 On nibble 3: cout SHALL take the slice cout and overflow the slice overflow for ADD/SUB, both 0 for other ops.
REQ-018 For SLT, result SHALL be 16'h0001 if the nibble-3 slice set is 1, else 16'h0000 (set = bit 15 of a-b, not overflow-corrected).
REQ-019 Unsupported op codes SHALL still run 4 cycles and SHALL return result 16'h0000, zero 1, cout 0, overflow 0.
REQ-020 zero SHALL reflect the final result (after SLT fix-up) and SHALL be valid whenever out_valid is 1.
REQ-021 In DONE, out_valid SHALL stay 1 and result/flags SHALL stay stable until out_ready is 1; on out_valid & out_ready, state SHALL go to IDLE.
REQ-022 No request SHALL be accepted in the cycle the result is taken; the minimum issue interval is 6 cycles.
REQ-023 result/cout/overflow/zero SHALL hold their last values after the handshake until the next completion overwrites them.
REQ-024 in_valid while not in IDLE SHALL be ignored and SHALL not disturb captured operands.

Reset
REQ-025 On rst_n low, asynchronously: state IDLE, in_ready 1 after reset, out_valid 0, result 0, cout 0, overflow 0, zero 1, k 0, carry register 0.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort the operation with no partial out_valid.

Structure
REQ-027 A shared package SHALL hold the op-code constants, the state enum, and NIBBLES = 4.
REQ-028 The block SHALL instantiate exactly one sub-module, the existing 4-bit ALU slice ALU4Bit, reused across the 4 nibble cycles.

Verification
REQ-029 ADD a=16'h0FFF b=16'h0001 -> out_valid 5 cycles after accept, result 16'h1000, cout 0, overflow 0, zero 0.
REQ-030 ADD a=16'h7FFF b=16'h0001 -> result 16'h8000, overflow 1; SUB a=16'h1234 b=16'h1234 -> result 0, zero 1, cout 1.
REQ-031 SLT a=16'hFFFE b=16'h0003 -> result 16'h0001; SLT a=16'h0005 b=16'h0003 -> result 16'h0000, zero 1.
REQ-032 AND a=16'hF0F0 b=16'hFF00 -> 16'hF000; OR -> 16'hFFF0; op 011 -> result 0, zero 1.
REQ-033 Hold out_ready 0 for 3 cycles in DONE while toggling in_valid/a -> out_valid and result stable, no new accept; in_ready 1 the cycle after the handshake.
REQ-034 Assert rst_n low during RUN cycle 2 -> all outputs at reset values, next request completes correctly.
